// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared opcode, PC-source, state and trap-cause definitions for the NPC core
package npc_pkg;

    // RV32 major opcodes that influence PC selection
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Next-PC source encodings
    localparam logic [1:0] PC_SRC_PLUS4     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU       = 2'b01;
    localparam logic [1:0] PC_SRC_ALU_ALIGN = 2'b10;

    // Trap cause codes
    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_MISALIGN = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_TRAP  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC source decode and target computation
//
// Ports:
//   opcode       in   7     inst[6:0] of the instruction being executed
//   branch_taken in   1     branch condition from execute
//   pc           in   XLEN  current architectural PC
//   alu_result   in   XLEN  jump/branch target from the ALU
//   pc_src       out  2     selected source (PC_SRC_*)
//   next_pc      out  XLEN  candidate next PC
//   misaligned   out  1     next_pc is not word aligned
module pc_next_sel
    import npc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_result,
    output logic [1:0]      pc_src,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        pc_src = PC_SRC_PLUS4;
        case (opcode)
            OP_JAL:    pc_src = PC_SRC_ALU;
            OP_JALR:   pc_src = PC_SRC_ALU_ALIGN;
            OP_BRANCH: pc_src = branch_taken ? PC_SRC_ALU : PC_SRC_PLUS4;
            OP_AUIPC,
            OP_LUI:    pc_src = PC_SRC_PLUS4;
            default:   pc_src = PC_SRC_PLUS4;
        endcase
    end

    always_comb begin
        next_pc = pc + XLEN'(4);
        case (pc_src)
            PC_SRC_ALU:       next_pc = alu_result;
            PC_SRC_ALU_ALIGN: next_pc = {alu_result[XLEN-1:1], 1'b0};
            default:          next_pc = pc + XLEN'(4);
        endcase
    end

    // jalr clears only bit 0, so bit 1 can still leave the target misaligned
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - multi-cycle PC sequencer: fetch, hand off, await execute, commit next PC
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   ifu_req_valid/ready/addr      fetch request handshake, addr is the current pc
//   ifu_rsp_valid/inst            single-cycle fetch response
//   inst_valid, inst              1-cycle new-instruction pulse, latched instruction
//   pc                            architectural PC (this block is its only writer)
//   exec_done, alu_result,
//   branch_taken                  execute completion and branch/jump inputs
//   pc_src                        PC source selected for the current instruction
//   commit                        1-cycle pulse on the edge that updates pc
//   trap, trap_cause              sticky trap flag and reason
module pc_seq_ctrl
    import npc_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_rsp_valid,
    input  logic [31:0]     ifu_rsp_inst,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    input  logic            exec_done,
    input  logic [XLEN-1:0] alu_result,
    input  logic            branch_taken,
    output logic [1:0]      pc_src,
    output logic            commit,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    localparam logic [31:0] MAX_WAIT_W = MAX_WAIT;

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            req_valid_q, req_valid_d;
    logic            commit_q, commit_d;
    logic            trap_q, trap_d;
    logic [1:0]      trap_cause_q, trap_cause_d;
    logic [31:0]     wait_cnt_q, wait_cnt_d;

    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic [31:0]     wait_cnt_inc;
    logic            timeout_hit;

    pc_next_sel #(.XLEN(XLEN)) u_next_sel (
        .opcode       (inst_q[6:0]),
        .branch_taken (branch_taken),
        .pc           (pc_q),
        .alu_result   (alu_result),
        .pc_src       (pc_src),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    // The budget spans FETCH and WAIT together; a handshake in the same
    // cycle the budget runs out takes priority over the timeout.
    assign wait_cnt_inc = wait_cnt_q + 32'd1;
    assign timeout_hit  = (MAX_WAIT_W != 32'd0) && (wait_cnt_inc >= MAX_WAIT_W);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        commit_d     = 1'b0;
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_FETCH;
                wait_cnt_d = 32'd0;
            end
            ST_FETCH: begin
                wait_cnt_d = wait_cnt_inc;
                if (ifu_req_ready) begin
                    state_d = ST_WAIT;
                end else if (timeout_hit) begin
                    state_d      = ST_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = TRAP_TIMEOUT;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_inc;
                if (ifu_rsp_valid) begin
                    state_d      = ST_EXEC;
                    inst_d       = ifu_rsp_inst;
                    inst_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d      = ST_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = TRAP_TIMEOUT;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (misaligned) begin
                        state_d      = ST_TRAP;
                        trap_d       = 1'b1;
                        trap_cause_d = TRAP_MISALIGN;
                    end else begin
                        state_d    = ST_FETCH;
                        pc_d       = next_pc;
                        commit_d   = 1'b1;
                        wait_cnt_d = 32'd0;
                    end
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the request rises together with the FETCH state
        req_valid_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= XLEN'(RESET_PC);
            inst_q       <= 32'd0;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b0;
            commit_q     <= 1'b0;
            trap_q       <= 1'b0;
            trap_cause_q <= TRAP_NONE;
            wait_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            req_valid_q  <= req_valid_d;
            commit_q     <= commit_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign ifu_req_valid = req_valid_q;
    assign ifu_req_addr  = pc_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign inst_valid    = inst_valid_q;
    assign commit        = commit_q;
    assign trap          = trap_q;
    assign trap_cause    = trap_cause_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;

    localparam logic [31:0] I_ADDI = 32'h0000_0013;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_0067;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exec_done;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [1:0]  pc_src;
    logic        commit;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] o_addr;
    logic        o_ivld;
    logic [1:0]  o_src;
    logic        o_cm_exec;

    pc_seq_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000),
        .MAX_WAIT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .pc            (pc),
        .exec_done     (exec_done),
        .alu_result    (alu_result),
        .branch_taken  (branch_taken),
        .pc_src        (pc_src),
        .commit        (commit),
        .trap          (trap),
        .trap_cause    (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n         = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'd0;
        exec_done     = 1'b0;
        alu_result    = 32'd0;
        branch_taken  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entered on a negedge with the DUT in FETCH; returns on the negedge
    // after the exec_done edge. Ready and response come as early as possible.
    task automatic drive_inst(input logic [31:0] i, input logic [31:0] alu, input logic tk,
                              output logic [31:0] addr, output logic ivld,
                              output logic [1:0] src, output logic cm_exec);
        addr = ifu_req_addr;
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = i;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        ivld          = inst_valid;
        cm_exec       = commit;
        alu_result    = alu;
        branch_taken  = tk;
        #1 src = pc_src;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done    = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b exp 0", ifu_req_valid); end
        n_cmp++; if (pc !== 32'h8000_0000) begin n_err++; $display("FAIL reset_pc: got %h exp 80000000", pc); end
        n_cmp++; if (inst !== 32'd0) begin n_err++; $display("FAIL reset_inst: got %h exp 0", inst); end
        n_cmp++; if ({inst_valid, commit, trap} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b exp 000", {inst_valid, commit, trap}); end
        n_cmp++; if (trap_cause !== 2'b00) begin n_err++; $display("FAIL reset_cause: got %b exp 00", trap_cause); end
    endtask

    task automatic test_basic_addi();
        ifu_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (ifu_req_valid !== 1'b1) begin n_err++; $display("FAIL addi_req_valid: got %b exp 1", ifu_req_valid); end
        drive_inst(I_ADDI, 32'h1234_5678, 1'b0, o_addr, o_ivld, o_src, o_cm_exec);
        n_cmp++; if (o_addr !== 32'h8000_0000) begin n_err++; $display("FAIL addi_addr: got %h exp 80000000", o_addr); end
        n_cmp++; if (o_ivld !== 1'b1) begin n_err++; $display("FAIL addi_inst_valid: got %b exp 1", o_ivld); end
        n_cmp++; if (o_src !== 2'b00) begin n_err++; $display("FAIL addi_pc_src: got %b exp 00", o_src); end
        n_cmp++; if (o_cm_exec !== 1'b0) begin n_err++; $display("FAIL addi_early_commit: got %b exp 0", o_cm_exec); end
        n_cmp++; if (commit !== 1'b1) begin n_err++; $display("FAIL addi_commit_cycle4: got %b exp 1", commit); end
        n_cmp++; if (pc !== 32'h8000_0004) begin n_err++; $display("FAIL addi_pc: got %h exp 80000004", pc); end
        n_cmp++; if (inst !== I_ADDI) begin n_err++; $display("FAIL addi_inst: got %h exp %h", inst, I_ADDI); end
        n_cmp++; if (ifu_req_valid !== 1'b1) begin n_err++; $display("FAIL addi_refetch: got %b exp 1", ifu_req_valid); end
    endtask

    task automatic test_jal();
        drive_inst(I_JAL, 32'h8000_0100, 1'b0, o_addr, o_ivld, o_src, o_cm_exec);
        n_cmp++; if (o_addr !== 32'h8000_0004) begin n_err++; $display("FAIL jal_addr: got %h exp 80000004", o_addr); end
        n_cmp++; if (o_src !== 2'b01) begin n_err++; $display("FAIL jal_pc_src: got %b exp 01", o_src); end
        n_cmp++; if (commit !== 1'b1) begin n_err++; $display("FAIL jal_commit: got %b exp 1", commit); end
        n_cmp++; if (pc !== 32'h8000_0100) begin n_err++; $display("FAIL jal_pc: got %h exp 80000100", pc); end
        @(negedge clk);
        n_cmp++; if (commit !== 1'b0) begin n_err++; $display("FAIL jal_commit_pulse: got %b exp 0", commit); end
        n_cmp++; if (ifu_req_addr !== 32'h8000_0100) begin n_err++; $display("FAIL jal_next_addr: got %h exp 80000100", ifu_req_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL jal_ivld_pulse: got %b exp 0", inst_valid); end
    endtask

    task automatic test_branch();
        drive_inst(I_BEQ, 32'h8000_0040, 1'b1, o_addr, o_ivld, o_src, o_cm_exec);
        n_cmp++; if (o_src !== 2'b01) begin n_err++; $display("FAIL beq_taken_src: got %b exp 01", o_src); end
        n_cmp++; if (pc !== 32'h8000_0040) begin n_err++; $display("FAIL beq_taken_pc: got %h exp 80000040", pc); end
        drive_inst(I_BEQ, 32'h8000_0040, 1'b0, o_addr, o_ivld, o_src, o_cm_exec);
        n_cmp++; if (o_src !== 2'b00) begin n_err++; $display("FAIL beq_not_taken_src: got %b exp 00", o_src); end
        n_cmp++; if (pc !== 32'h8000_0044) begin n_err++; $display("FAIL beq_not_taken_pc: got %h exp 80000044", pc); end
    endtask

    task automatic test_wrap();
        drive_inst(I_JAL, 32'hFFFF_FFFC, 1'b0, o_addr, o_ivld, o_src, o_cm_exec);
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_jump_pc: got %h exp fffffffc", pc); end
        drive_inst(I_ADDI, 32'h0000_0000, 1'b0, o_addr, o_ivld, o_src, o_cm_exec);
        n_cmp++; if (o_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h exp fffffffc", o_addr); end
        n_cmp++; if (pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc: got %h exp 00000000", pc); end
        n_cmp++; if (commit !== 1'b1) begin n_err++; $display("FAIL wrap_commit: got %b exp 1", commit); end
    endtask

    task automatic test_jalr_trap();
        drive_inst(I_JALR, 32'h8000_0203, 1'b0, o_addr, o_ivld, o_src, o_cm_exec);
        n_cmp++; if (o_src !== 2'b10) begin n_err++; $display("FAIL jalr_src: got %b exp 10", o_src); end
        n_cmp++; if (trap !== 1'b1) begin n_err++; $display("FAIL jalr_trap: got %b exp 1", trap); end
        n_cmp++; if (trap_cause !== 2'b01) begin n_err++; $display("FAIL jalr_cause: got %b exp 01", trap_cause); end
        n_cmp++; if (commit !== 1'b0) begin n_err++; $display("FAIL jalr_commit: got %b exp 0", commit); end
        n_cmp++; if (pc !== 32'h0000_0000) begin n_err++; $display("FAIL jalr_pc_held: got %h exp 00000000", pc); end
        n_cmp++; if (ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL jalr_req_valid: got %b exp 0", ifu_req_valid); end
        // TRAP is terminal: further handshakes and exec_done change nothing
        exec_done     = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_req_ready = 1'b1;
        @(negedge clk);
        exec_done     = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_req_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if ({trap, ifu_req_valid, commit, inst_valid} !== 4'b1000) begin n_err++; $display("FAIL trap_terminal: got %b exp 1000", {trap, ifu_req_valid, commit, inst_valid}); end
        n_cmp++; if (pc !== 32'h0000_0000) begin n_err++; $display("FAIL trap_pc_stable: got %h exp 00000000", pc); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++; if ({ifu_req_valid, trap} !== 2'b10) begin n_err++; $display("FAIL timeout_fetch_c%0d: got %b exp 10", k, {ifu_req_valid, trap}); end
        end
        @(negedge clk);
        n_cmp++; if (trap !== 1'b1) begin n_err++; $display("FAIL timeout_trap: got %b exp 1", trap); end
        n_cmp++; if (trap_cause !== 2'b10) begin n_err++; $display("FAIL timeout_cause: got %b exp 10", trap_cause); end
        n_cmp++; if (ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL timeout_req_drop: got %b exp 0", ifu_req_valid); end
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = I_JAL;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stray_rsp_ivld: got %b exp 0", inst_valid); end
        n_cmp++; if (inst !== 32'd0) begin n_err++; $display("FAIL stray_rsp_inst: got %h exp 0", inst); end
        n_cmp++; if (trap_cause !== 2'b10) begin n_err++; $display("FAIL stray_rsp_cause: got %b exp 10", trap_cause); end
    endtask

    task automatic test_handshake_at_limit();
        do_reset();
        repeat (8) @(negedge clk);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        n_cmp++; if ({trap, ifu_req_valid} !== 2'b00) begin n_err++; $display("FAIL limit_req_wins: got %b exp 00", {trap, ifu_req_valid}); end
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = I_ADDI;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL limit_rsp_wins: got %b exp 0", trap); end
        n_cmp++; if ({inst_valid, inst} !== {1'b1, I_ADDI}) begin n_err++; $display("FAIL limit_inst: got %b/%h exp 1/%h", inst_valid, inst, I_ADDI); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        @(negedge clk);
        drive_inst(I_ADDI, 32'h0, 1'b0, o_addr, o_ivld, o_src, o_cm_exec);
        n_cmp++; if (pc !== 32'h8000_0004) begin n_err++; $display("FAIL rstw_pre_pc: got %h exp 80000004", pc); end
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL rstw_req_valid: got %b exp 0", ifu_req_valid); end
        n_cmp++; if (pc !== 32'h8000_0000) begin n_err++; $display("FAIL rstw_pc: got %h exp 80000000", pc); end
        n_cmp++; if (inst !== 32'd0) begin n_err++; $display("FAIL rstw_inst: got %h exp 0", inst); end
        n_cmp++; if ({inst_valid, commit, trap} !== 3'b000) begin n_err++; $display("FAIL rstw_pulses: got %b exp 000", {inst_valid, commit, trap}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ifu_req_valid, ifu_req_addr} !== {1'b1, 32'h8000_0000}) begin n_err++; $display("FAIL rstw_refetch: got %b/%h exp 1/80000000", ifu_req_valid, ifu_req_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_addi();
        test_jal();
        test_branch();
        test_wrap();
        test_jalr_trap();
        test_timeout();
        test_handshake_at_limit();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
